// File: rtl/debug_dump_tx.sv
// Streams a pipeline-register snapshot out over a byte UART: header 0xA5, then 36
// payload bytes. Define DEBUG_DUMP_CHECKSUM_EN to append an XOR checksum byte.
module debug_dump_tx #(
  parameter int NB_DATA    = 8,
  parameter int NB_ID_EX   = 144,
  parameter int NB_EX_MEM  = 32,
  parameter int NB_MEM_WB  = 48,
  parameter int NB_WB_ID   = 40,
  parameter int NB_CONTROL = 24
) (
  input  logic                  clk,
  input  logic                  i_reset,
  input  logic                  i_dump_req,
  input  logic [NB_ID_EX-1:0]   i_segment_registers_ID_EX,
  input  logic [NB_EX_MEM-1:0]  i_segment_registers_EX_MEM,
  input  logic [NB_MEM_WB-1:0]  i_segment_registers_MEM_WB,
  input  logic [NB_WB_ID-1:0]   i_segment_registers_WB_ID,
  input  logic [NB_CONTROL-1:0] i_control_registers_ID_EX,
  input  logic                  i_txDone,
  output logic                  o_tx_start,
  output logic [NB_DATA-1:0]    o_data,
  output logic                  o_busy,
  output logic                  o_done
);

  localparam int NB_SHADOW = NB_ID_EX + NB_EX_MEM + NB_MEM_WB + NB_WB_ID + NB_CONTROL;
  localparam logic [NB_DATA-1:0] HEADER = NB_DATA'(8'hA5);
`ifdef DEBUG_DUMP_CHECKSUM_EN
  localparam logic [5:0] LAST_IDX = 6'd37;
`else
  localparam logic [5:0] LAST_IDX = 6'd36;
`endif

  typedef enum logic [2:0] {IDLE, LOAD, SEND, WAIT, DONE} state_t;

  state_t               state;
  logic [NB_SHADOW-1:0] shadow;
  logic [5:0]           cnt;
  logic [NB_DATA-1:0]   payload_byte;
`ifdef DEBUG_DUMP_CHECKSUM_EN
  logic [NB_DATA-1:0]   checksum;
`endif

  // The shadow is shifted right as bytes go out, so the next payload byte is
  // always its low byte; field order falls out of the concatenation order.
  assign payload_byte = shadow[NB_DATA-1:0];

  // NOTE: all state, including the wide shadow, uses non-blocking assignments
  // and is cleared on reset so an aborted frame leaves no stale snapshot.
  always_ff @(posedge clk) begin
    if (i_reset) begin
      state      <= IDLE;
      shadow     <= '0;
      cnt        <= '0;
      o_tx_start <= 1'b0;
      o_data     <= '0;
      o_busy     <= 1'b0;
      o_done     <= 1'b0;
`ifdef DEBUG_DUMP_CHECKSUM_EN
      checksum   <= '0;
`endif
    end else begin
      o_tx_start <= 1'b0;
      o_done     <= 1'b0;
      case (state)
        IDLE: begin
          if (i_dump_req) begin
            state  <= LOAD;
            o_busy <= 1'b1;
          end
        end
        LOAD: begin
          shadow     <= {i_control_registers_ID_EX, i_segment_registers_WB_ID,
                         i_segment_registers_MEM_WB, i_segment_registers_EX_MEM,
                         i_segment_registers_ID_EX};
          cnt        <= '0;
`ifdef DEBUG_DUMP_CHECKSUM_EN
          checksum   <= '0;
`endif
          o_data     <= HEADER;
          o_tx_start <= 1'b1;
          state      <= SEND;
        end
        SEND: state <= WAIT;
        WAIT: begin
          if (i_txDone) begin
            cnt <= cnt + 6'd1;
            if (cnt == LAST_IDX) begin
              state  <= DONE;
              o_busy <= 1'b0;
              o_done <= 1'b1;
            end else begin
              state      <= SEND;
              o_tx_start <= 1'b1;
`ifdef DEBUG_DUMP_CHECKSUM_EN
              if (cnt == LAST_IDX - 6'd1) begin
                o_data <= checksum;
              end else begin
                o_data   <= payload_byte;
                checksum <= checksum ^ payload_byte;
                shadow   <= shadow >> NB_DATA;
              end
`else
              o_data <= payload_byte;
              shadow <= shadow >> NB_DATA;
`endif
            end
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule
